// File: rtl/conv_out_packer.sv
// Packs the convolution core's unstallable pixel stream into OUT_W-bit words, frames them
// by frame_len, and buffers them in a first-word-fall-through FIFO for a valid/ready consumer.
module conv_out_packer #(
  parameter int PIX_W      = 8,
  parameter int OUT_W      = 32,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             valid_in,
  input  logic [PIX_W-1:0] px_in,
  input  logic [15:0]      frame_len,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             overflow,
  output logic             busy,
  output logic             state_dbg
);

  localparam int LANES = OUT_W / PIX_W;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [15:0]      len_q, len_d, pix_cnt_q, pix_cnt_d, eff_len;
  logic [LW-1:0]    lane_q, lane_d;
  logic [OUT_W-1:0] acc_q, acc_d, word;
  logic             accept, word_done, word_last;

  logic             stage_vld_q, stage_last_q;
  logic [OUT_W-1:0] stage_data_q;

  logic [OUT_W:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             empty, full, pop, push_ok, drop;
  logic             overflow_q;

  // Packing FSM: pix_cnt_d is the 1-based index of the pixel accepted this cycle.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    pix_cnt_d = pix_cnt_q;
    lane_d    = lane_q;
    acc_d     = acc_q;
    eff_len   = len_q;
    accept    = 1'b0;
    word_done = 1'b0;
    word_last = 1'b0;
    word      = acc_q;
    for (int k = 0; k < LANES; k++) begin
      if (lane_q == LW'(k)) word[k*PIX_W +: PIX_W] = px_in;
    end
    case (state_q)
      IDLE: begin
        if (valid_in && frame_len != 16'd0) begin
          accept    = 1'b1;
          len_d     = frame_len;
          eff_len   = frame_len;
          pix_cnt_d = 16'd1;
        end
      end
      ACTIVE: begin
        if (valid_in) begin
          accept    = 1'b1;
          pix_cnt_d = pix_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      word_last = (pix_cnt_d == eff_len);
      word_done = word_last || (lane_q == LW'(LANES - 1));
      state_d   = word_last ? IDLE : ACTIVE;
      if (word_done) begin
        acc_d  = '0;
        lane_d = '0;
      end else begin
        acc_d  = word;
        lane_d = lane_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      state_q      <= IDLE;
      len_q        <= '0;
      pix_cnt_q    <= '0;
      lane_q       <= '0;
      acc_q        <= '0;
      stage_vld_q  <= 1'b0;
      stage_last_q <= 1'b0;
      stage_data_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pix_cnt_q   <= pix_cnt_d;
      lane_q      <= lane_d;
      acc_q       <= acc_d;
      stage_vld_q <= word_done;
      if (word_done) begin
        stage_data_q <= word;
        stage_last_q <= word_last;
      end
    end
  end

  // Output handshake: the head word transfers on any edge where out_valid && out_ready;
  // while out_valid is high and out_ready low, head, out_data and out_last hold steady.
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign pop     = !empty && out_ready;
  assign push_ok = stage_vld_q && (!full || pop);
  assign drop    = stage_vld_q && full && !pop;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= {stage_last_q, stage_data_q};
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push_ok && !pop)      count_q <= count_q + CW'(1);
      else if (!push_ok && pop) count_q <= count_q - CW'(1);
      if (drop) overflow_q <= 1'b1;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0   : mem[rd_ptr_q][OUT_W-1:0];
  assign out_last  = empty ? 1'b0 : mem[rd_ptr_q][OUT_W];
  assign overflow  = overflow_q;
  assign busy      = (state_q == ACTIVE) || stage_vld_q || !empty;
  assign state_dbg = (state_q == ACTIVE);

endmodule

// File: tb/tb_conv_out_packer.sv
// Directed bench for conv_out_packer (FIFO_DEPTH=4): expected words live in exp_q and are
// compared as the consumer accepts each head word.
module tb_conv_out_packer;

  localparam int PIX_W = 8;
  localparam int OUT_W = 32;

  logic             clk = 1'b0;
  logic             rstn, valid_in, clear, out_ready;
  logic [PIX_W-1:0] px_in;
  logic [15:0]      frame_len;
  logic             out_valid, out_last, overflow, busy, state_dbg;
  logic [OUT_W-1:0] out_data;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [OUT_W:0] exp_q[$];

  conv_out_packer #(.PIX_W(PIX_W), .OUT_W(OUT_W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rstn(rstn), .valid_in(valid_in), .px_in(px_in), .frame_len(frame_len),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .overflow(overflow), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic last, input logic [OUT_W-1:0] data);
    exp_q.push_back({last, data});
  endtask

  // Drives n back-to-back pixels first_px, first_px+1, ... with the given frame_len.
  task automatic send(input logic [15:0] len, input int n, input int first_px);
    for (int i = 0; i < n; i++) begin
      valid_in  = 1'b1;
      frame_len = len;
      px_in     = PIX_W'(first_px + i);
      tick();
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      tick();
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard: bit 33 marks that an expected word existed at all.
  always @(negedge clk) begin
    if (rstn && !clear && out_valid && out_ready) begin
      if (exp_q.size() > 0) check("word", {30'd0, 1'b1, out_last, out_data}, {30'd0, 1'b1, exp_q.pop_front()});
      else                  check("word_unexpected", {30'd0, 1'b1, out_last, out_data}, 64'd0);
    end
  end

  initial begin
    rstn = 1'b0; clear = 1'b0; out_ready = 1'b0;
    valid_in = 1'b1; px_in = 8'h55; frame_len = 16'd8;

    // T1: reset with valid_in asserted
    repeat (3) tick();
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_out_data",  64'(out_data),  64'd0);
    check("t1_out_last",  64'(out_last),  64'd0);
    check("t1_overflow",  64'(overflow),  64'd0);
    check("t1_busy",      64'(busy),      64'd0);
    valid_in = 1'b0;
    rstn = 1'b1;
    tick();

    // T2: 8-pixel frame, latency of first word
    out_ready = 1'b1;
    push_exp(1'b0, 32'h04030201);
    push_exp(1'b1, 32'h08070605);
    for (int i = 1; i <= 8; i++) begin
      valid_in = 1'b1; frame_len = 16'd8; px_in = PIX_W'(i);
      tick();
      if (i == 4) check("t2_lat_n",  64'(out_valid), 64'd0);
      if (i == 5) check("t2_lat_n1", 64'(out_valid), 64'd1);
    end
    valid_in = 1'b0;
    wait_idle("t2");

    // T3: short final word, upper lanes zero
    push_exp(1'b0, 32'h04030201);
    push_exp(1'b1, 32'h00000605);
    send(16'd6, 6, 1);
    wait_idle("t3");

    // T4: overflow with stalled consumer
    out_ready = 1'b0;
    send(16'd20, 20, 1);
    check("t4_ovf_before", 64'(overflow), 64'd0);
    tick();
    check("t4_ovf_after", 64'(overflow), 64'd1);
    repeat (3) tick();
    check("t4_stall_valid", 64'(out_valid), 64'd1);
    check("t4_stall_data",  64'(out_data),  64'h04030201);
    check("t4_stall_last",  64'(out_last),  64'd0);
    check("t4_stall_busy",  64'(busy),      64'd1);
    push_exp(1'b0, 32'h04030201);
    push_exp(1'b0, 32'h08070605);
    push_exp(1'b0, 32'h0C0B0A09);
    push_exp(1'b0, 32'h100F0E0D);
    out_ready = 1'b1;
    wait_idle("t4");
    check("t4_ovf_sticky", 64'(overflow), 64'd1);

    // T5: clear mid-frame
    clear = 1'b1; tick(); clear = 1'b0;
    check("t5_ovf_cleared", 64'(overflow), 64'd0);
    send(16'd8, 3, 1);
    clear = 1'b1; valid_in = 1'b1; px_in = 8'h99;
    tick();
    clear = 1'b0; valid_in = 1'b0;
    check("t5_clr_valid", 64'(out_valid), 64'd0);
    check("t5_clr_busy",  64'(busy),      64'd0);
    push_exp(1'b1, 32'h04030201);
    send(16'd4, 4, 1);
    wait_idle("t5");

    // T6: zero-length frames, then two back-to-back 4-pixel frames
    send(16'd0, 3, 8'h77);
    check("t6_zero_busy",  64'(busy),      64'd0);
    check("t6_zero_valid", 64'(out_valid), 64'd0);
    push_exp(1'b1, 32'h04030201);
    push_exp(1'b1, 32'h08070605);
    send(16'd4, 4, 1);
    send(16'd4, 4, 5);
    wait_idle("t6");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
